// File: rtl/data_matrix_pkg.sv
// Shared encodings and types for the LC-3 datapath slice: register-file selects,
// condition-code constants and the 16-bit datapath word.
package data_matrix_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        DR_IR11_9 = 2'b00,
        DR_R7     = 2'b01,
        DR_R6     = 2'b10,
        DR_RSVD   = 2'b11
    } dr_sel_e;

    typedef enum logic [1:0] {
        SR1_IR11_9 = 2'b00,
        SR1_IR8_6  = 2'b01,
        SR1_R6     = 2'b10,
        SR1_RSVD   = 2'b11
    } sr1_sel_e;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

    localparam int unsigned NUM_REGS = 8;

endpackage

// File: rtl/data_matrix_nzp_gen.sv
// Combinational condition-code generator: classifies a bus word as negative,
// zero or positive, always producing a one-hot {n,z,p}.
module data_matrix_nzp_gen
    import data_matrix_pkg::*;
(
    input  logic [15:0] bus,
    output logic [2:0]  nzp
);

    // Sign bit takes priority; otherwise zero-compare decides Z versus P.
    always_comb begin
        nzp = NZP_Z;
        if (bus[15] == 1'b1) begin
            nzp = NZP_N;
        end else if (bus == 16'h0000) begin
            nzp = NZP_Z;
        end else begin
            nzp = NZP_P;
        end
    end

endmodule

// File: rtl/data_matrix_regfile.sv
// LC-3 register file R0-R7 with condition-code and branch-enable registers,
// loaded from the shared datapath bus and feeding SR1/SR2 to the ALU.
module data_matrix_regfile
    import data_matrix_pkg::*;
#(
    parameter logic [2:0] RST_NZP = 3'b010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bus,
    input  logic [15:0] ir,
    input  logic        ld_reg,
    input  logic        ld_cc,
    input  logic        ld_ben,
    input  logic [1:0]  dr_mux,
    input  logic [1:0]  sr1_mux,
    output logic [15:0] sr1,
    output logic [15:0] sr2,
    output logic        n,
    output logic        z,
    output logic        p,
    output logic        ben
);

    word_t       regs_r [NUM_REGS];
    logic [2:0]  nzp_r;
    logic        ben_r;

    dr_sel_e     dr_sel_s;
    sr1_sel_e    sr1_sel_s;
    logic [2:0]  dest_s;
    logic        wr_en_s;
    logic [2:0]  sr1_idx_s;
    logic [2:0]  nzp_next_s;
    logic        ben_next_s;

    assign dr_sel_s  = dr_sel_e'(dr_mux);
    assign sr1_sel_s = sr1_sel_e'(sr1_mux);

    data_matrix_nzp_gen u_nzp_gen (
        .bus (bus),
        .nzp (nzp_next_s)
    );

    // Destination decode; the reserved select suppresses the write entirely.
    always_comb begin
        dest_s  = 3'd0;
        wr_en_s = 1'b0;
        case (dr_sel_s)
            DR_IR11_9: begin
                dest_s  = ir[11:9];
                wr_en_s = ld_reg;
            end
            DR_R7: begin
                dest_s  = 3'd7;
                wr_en_s = ld_reg;
            end
            DR_R6: begin
                dest_s  = 3'd6;
                wr_en_s = ld_reg;
            end
            default: begin
                dest_s  = 3'd0;
                wr_en_s = 1'b0;
            end
        endcase
    end

    // SR1 source decode; the reserved select reads R0.
    always_comb begin
        sr1_idx_s = 3'd0;
        case (sr1_sel_s)
            SR1_IR11_9: sr1_idx_s = ir[11:9];
            SR1_IR8_6:  sr1_idx_s = ir[8:6];
            SR1_R6:     sr1_idx_s = 3'd6;
            default:    sr1_idx_s = 3'd0;
        endcase
    end

    // Branch enable always sees the NZP held before this edge.
    always_comb begin
        ben_next_s = (ir[11] & nzp_r[2]) | (ir[10] & nzp_r[1]) | (ir[9] & nzp_r[0]);
    end

    // Register array storage; reads are unbypassed, so same-cycle reads see old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 16'h0000;
            end
        end else if (wr_en_s) begin
            regs_r[dest_s] <= bus;
        end
    end

    // Condition-code register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzp_r <= RST_NZP;
        end else if (ld_cc) begin
            nzp_r <= nzp_next_s;
        end
    end

    // Branch-enable register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ben_r <= 1'b0;
        end else if (ld_ben) begin
            ben_r <= ben_next_s;
        end
    end

    assign sr1 = regs_r[sr1_idx_s];
    assign sr2 = regs_r[ir[2:0]];
    assign n   = nzp_r[2];
    assign z   = nzp_r[1];
    assign p   = nzp_r[0];
    assign ben = ben_r;

endmodule

// File: doc/data_matrix_regfile.md
# data_matrix_regfile

LC-3 general-purpose register file, condition-code register and branch-enable latch. It sits on the load side of the shared 16-bit datapath bus, which the ALU and the other gated sources drive. It captures bus values into R0–R7, updates NZP from the bus value and evaluates BEN. It also supplies the SR1/SR2 operands back to the ALU inputs.

## Interface
Parameters:
- RST_NZP, 3'b010: reset value of {n,z,p}.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- bus, input, 16: shared datapath bus; must be driven (not Z) in any cycle where a load enable is high.
- ir, input, 16: current instruction register value.
- ld_reg, input, 1: write bus into the register selected by dr_mux.
- ld_cc, input, 1: update NZP from bus.
- ld_ben, input, 1: update BEN from ir[11:9] and the current NZP.
- dr_mux, input, 2: destination select. 00 = ir[11:9], 01 = R7, 10 = R6, 11 = reserved (no write).
- sr1_mux, input, 2: SR1 select. 00 = ir[11:9], 01 = ir[8:6], 10 = R6, 11 = reserved (reads R0).
- sr1, output, 16: read port 1 data.
- sr2, output, 16: read port 2 data, always R[ir[2:0]].
- n / z / p, output, 1 each: condition-code register.
- ben, output, 1: branch-enable register.

## Operation
- Storage: eight 16-bit registers R0–R7, a 3-bit NZP register and a 1-bit BEN register. All are flops.
- Reads: sr1 and sr2 are purely combinational from the current register contents and the selects.
- Register write: when ld_reg=1 and dr_mux≠11, R[dest] ← bus at the clock edge. When dr_mux=11, ld_reg is ignored.
- CC update: when ld_cc=1, NZP is set from the bus value:
  - bus[15]=1 → 100.
  - bus==0 → 010.
  - otherwise → 001.
  - Exactly one bit is always set.
- BEN update: when ld_ben=1, ben ← (ir[11]&n) | (ir[10]&z) | (ir[9]&p), using the NZP value before this edge.
- Independence: ld_reg, ld_cc and ld_ben can be asserted in any combination in the same cycle.
  - With ld_cc and ld_ben in the same cycle, BEN uses the old NZP.
- Reset (rst_n=0, async):
  - R0–R7 ← 0.
  - {n,z,p} ← RST_NZP.
  - ben ← 0.
  - Reset asserted mid-operation discards any pending write. Outputs reflect reset values immediately, with no clock needed.
- Width rules: no arithmetic inside the block other than the zero-compare. Register width is fixed at 16.

## Timing
- Write latency: a bus value loaded at edge k is visible on sr1/sr2 after edge k.
- Read-during-write: a read of the register being written in the same cycle returns the old value. There is no bypass.
- NZP and BEN change only at clock edges, or on reset assertion.
- sr1/sr2 settle combinationally within the same cycle as a change in ir or sr1_mux. The ALU consumes them in that cycle.
- Load enables are level-sampled at every edge. Holding an enable high for N cycles performs N writes.
- rst_n deassertion is synchronised externally. The block performs no loads in the first edge after release unless an enable is high.

## Structure
- Shared package data_matrix_pkg:
  - DR_IR11_9 / DR_R7 / DR_R6 encodings.
  - SR1_IR11_9 / SR1_IR8_6 / SR1_R6 encodings.
  - NZP_N / NZP_Z / NZP_P constants.
  - 16-bit word typedef.
  - The ALU and the control FSM reuse the same package.
- One sub-module: data_matrix_nzp_gen, combinational, bus[15:0] → nzp[2:0]. The PSR logic reuses it later.

## Test plan
- Reset: drive rst_n=0 mid-cycle → all sr1/sr2 reads return 0000, nzp=010 and ben=0 with no clock edge.
- Write/read: ir[11:9]=3, ld_reg=1, dr_mux=00, bus=1234 → next cycle sr1_mux=00 gives sr1=1234. Set ir[2:0]=3 → sr2=1234. In the write cycle itself sr1 still reads 0000.
- CC generation: ld_cc with bus=8000 → nzp=100. bus=0000 → 010. bus=7FFF → 001. ld_cc=0 with bus=0000 → nzp unchanged.
- BEN ordering: nzp=001, ir[11:9]=001, then ld_cc (bus=0000) and ld_ben in the same cycle → ben=1 (old P), nzp=010. Next ld_ben → ben=0.
- Special destinations: dr_mux=01, bus=ABCD → R7=ABCD. dr_mux=10, bus=0F00 → R6=0F00, read via sr1_mux=10. dr_mux=11, bus=FFFF with ld_reg → no register changes.
- Reset mid-write: ld_reg=1, bus=5555, rst_n falls before the edge → R[dest]=0000 after reset, and the write is not performed.
